decode_imm_stage: RTL and testbench
===================================

# decode_imm_stage

Registered decode stage between instruction fetch and the register-read/issue stage. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake. It classifies the opcode into the shared instruction-type codes and builds the sign-extended immediate for that type. It presents the result through a 2-entry skid buffer, so IN_READY never depends combinationally on OUT_READY.

## Interface
- XLEN, 64, datapath/PC/immediate width.
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous kill of all buffered and incoming instructions.
- IN_VALID  input  1  fetch holds a valid instruction.
- IN_READY  output  1  stage can accept; registered.
- IN_PC  input  XLEN  PC of instruction.
- IN_INS  input  32  raw instruction.
- OUT_VALID  output  1  decoded instruction available.
- OUT_READY  input  1  downstream accepts.
- OUT_PC  output  XLEN  PC passthrough.
- OUT_INS  output  32  raw instruction passthrough.
- OUT_TYPE  output  3  utype/jtype/itype/btype/stype/rtype/ntype code (shared parameter header encodings).
- OUT_IMM  output  XLEN  sign-extended immediate.
- OUT_RD / OUT_RS1 / OUT_RS2  output  5 each  INS[11:7] / INS[19:15] / INS[24:20], raw.
- OUT_ILLEGAL  output  1  opcode not in the decode list.

## Operation
- Opcode map (INS[6:0]):
  - utype: lui 0110111, auipc 0010111.
  - jtype: jal 1101111.
  - btype: branch 1100011.
  - stype: store 0100011.
  - itype: jalr 1100111, load 0000011, op-imm 0010011, op-imm-32 0011011, system 1110011.
  - rtype: op 0110011, op-32 0111011, amo 0101111.
  - ntype: fence 0001111; any other opcode also decodes as ntype with OUT_ILLEGAL=1.
- Immediate, before sign-extension from bit 31 to XLEN:
  - itype: {{20{I[31]}},I[31:20]}.
  - stype: {{20{I[31]}},I[31:25],I[11:7]}.
  - btype: {{19{I[31]}},I[31],I[7],I[30:25],I[11:8],1'b0}.
  - utype: {I[31:12],12'b0}.
  - jtype: {{11{I[31]}},I[31],I[19:12],I[20],I[30:21],1'b0}.
  - rtype/ntype: 0.
- Decode is combinational on the input side. The main register and the skid register each hold the full decoded bundle plus a valid bit.
- Buffer states:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions, with acc = IN_VALID&IN_READY and drn = OUT_VALID&OUT_READY:
  - EMPTY: acc → ONE.
  - ONE: acc&drn → ONE, main reloaded with the new entry. acc&!drn → TWO, new entry to skid. !acc&drn → EMPTY.
  - TWO: drn → ONE, skid moves to main. Accepting is impossible because IN_READY=0.
- IN_READY = !skid_valid, registered. OUT_VALID = main_valid. Outputs come from main.
- FLUSH has priority over everything. At the next edge both valid bits clear, any same-cycle input is dropped, and IN_READY=1.
- Output data is held stable while OUT_VALID&!OUT_READY.

## Timing
- Reset (RST_N low, asynchronous): all valid bits 0. OUT_VALID=0, IN_READY=1, OUT_ILLEGAL=0. All data outputs 0, including OUT_TYPE=0 and OUT_IMM=0.
- Latency: 1 cycle from acceptance to OUT_VALID.
- Throughput: 1 instruction/cycle while OUT_READY is held high.
- IN_READY drops the cycle after the skid fills. It rises the cycle after the skid drains.
- Deasserting reset mid-stream: the stage starts in EMPTY, and no partial bundle is presented.
- Order is preserved. No instruction is lost or duplicated under any OUT_READY pattern.

## Test plan
- Reset, then ADDI x1,x0,-1 (0xFFF00093), PC 0x1000, OUT_READY=1 → next cycle: OUT_VALID=1, TYPE=itype, IMM=0xFFFF_FFFF_FFFF_FFFF, RD=1, PC=0x1000.
- Stream of four instructions:
  - LUI 0x123452B7 → utype, IMM=0x0000_0000_1234_5000.
  - JAL 0xFFDFF06F → jtype, IMM=-4.
  - SW 0x0020A423 → stype, IMM=8.
  - BEQ 0xFE000CE3 → btype, IMM=-8.
  - Required: 4 outputs on 4 consecutive cycles.
- Backpressure: OUT_READY=0 with three instructions offered → two accepted, then IN_READY=0. Raise OUT_READY → outputs appear in order, IN_READY back to 1 one cycle after the skid drains.
- FLUSH in state TWO with IN_VALID=1 → next cycle OUT_VALID=0, IN_READY=1, dropped input never appears.
- Opcode 0x7F (0x0000007F) → TYPE=ntype, IMM=0, OUT_ILLEGAL=1. Fence 0x0FF0000F → ntype, OUT_ILLEGAL=0.
- Random valid/ready/flush stress against a scoreboard, with async reset asserted mid-transfer → outputs 0 and IN_READY=1 immediately. Scoreboard checks no loss, no duplication, and in-order delivery.

Source files
------------

// File: rtl/decode_imm_stage_if.sv
// Handshake bundle for decode_imm_stage: fetch-side input and issue-side decoded output.
// slave = the decode stage itself; master = the fetch/issue environment around it.
interface decode_imm_stage_if #(parameter int XLEN = 64);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_ins;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_ins;
   logic [2:0]      out_type;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_pc, in_ins, out_ready,
      output in_ready, out_valid, out_pc, out_ins, out_type, out_imm,
             out_rd, out_rs1, out_rs2, out_illegal
   );

   modport master (
      output in_valid, in_pc, in_ins, out_ready,
      input  in_ready, out_valid, out_pc, out_ins, out_type, out_imm,
             out_rd, out_rs1, out_rs2, out_illegal
   );
endinterface

// File: rtl/decode_imm_stage.sv
// Opcode classify + sign-extended immediate build; 1-cycle latency, 1 instr/cycle.
// 2-entry skid buffer keeps in_ready registered (= !skid valid), never combinational on out_ready.
module decode_imm_stage #(
   parameter int XLEN = 64
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   decode_imm_stage_if.slave  bus
);

   localparam logic [2:0] ty_utype = 3'd0;
   localparam logic [2:0] ty_jtype = 3'd1;
   localparam logic [2:0] ty_itype = 3'd2;
   localparam logic [2:0] ty_btype = 3'd3;
   localparam logic [2:0] ty_stype = 3'd4;
   localparam logic [2:0] ty_rtype = 3'd5;
   localparam logic [2:0] ty_ntype = 3'd6;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     ins;
      logic [2:0]      typ;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } dec_t;

   typedef enum logic [1:0] {st_empty, st_one, st_two} state_t;

   logic [31:0] ins;
   logic [2:0]  typ;
   logic        illegal;
   logic [31:0] imm32;
   dec_t        dec;

   assign ins = bus.in_ins;

   always_comb begin
      typ     = ty_ntype;
      illegal = 1'b0;
      case (ins[6:0])
         7'b0110111, 7'b0010111:                       typ = ty_utype;
         7'b1101111:                                   typ = ty_jtype;
         7'b1100011:                                   typ = ty_btype;
         7'b0100011:                                   typ = ty_stype;
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0011011, 7'b1110011:                       typ = ty_itype;
         7'b0110011, 7'b0111011, 7'b0101111:           typ = ty_rtype;
         7'b0001111:                                   typ = ty_ntype;
         default: begin
            typ     = ty_ntype;
            illegal = 1'b1;
         end
      endcase
   end

   always_comb begin
      imm32 = 32'd0;
      case (typ)
         ty_itype: imm32 = {{20{ins[31]}}, ins[31:20]};
         ty_stype: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         ty_btype: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         ty_utype: imm32 = {ins[31:12], 12'b0};
         ty_jtype: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:  imm32 = 32'd0;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.pc      = bus.in_pc;
      dec.ins     = ins;
      dec.typ     = typ;
      dec.imm     = {{(XLEN-32){imm32[31]}}, imm32};
      dec.illegal = illegal;
   end

   state_t state;
   dec_t   main_q;
   dec_t   skid_q;
   logic   in_ready_q;
   logic   out_valid_q;
   logic   acc;
   logic   drn;

   assign acc = bus.in_valid & in_ready_q;
   assign drn = out_valid_q & bus.out_ready;

   // flush outranks every transition and drops the same-cycle input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= st_empty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         state       <= st_empty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            st_empty: begin
               if (acc) begin
                  main_q      <= dec;
                  out_valid_q <= 1'b1;
                  state       <= st_one;
               end
            end
            st_one: begin
               if (acc && drn) begin
                  main_q <= dec;
               end else if (acc) begin
                  skid_q     <= dec;
                  in_ready_q <= 1'b0;
                  state      <= st_two;
               end else if (drn) begin
                  out_valid_q <= 1'b0;
                  state       <= st_empty;
               end
            end
            st_two: begin
               if (drn) begin
                  main_q     <= skid_q;
                  in_ready_q <= 1'b1;
                  state      <= st_one;
               end
            end
            default: begin
               state       <= st_empty;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_pc      = main_q.pc;
   assign bus.out_ins     = main_q.ins;
   assign bus.out_type    = main_q.typ;
   assign bus.out_imm     = main_q.imm;
   assign bus.out_rd      = main_q.ins[11:7];
   assign bus.out_rs1     = main_q.ins[19:15];
   assign bus.out_rs2     = main_q.ins[24:20];
   assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Scoreboard bench for decode_imm_stage: directed vectors with hand-computed decode results.
module tb_decode_imm_stage;

   logic clk;
   logic rst_n;
   logic flush;

   decode_imm_stage_if #(.XLEN(64)) bus ();

   decode_imm_stage #(.XLEN(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
      logic [2:0]  typ;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   logic [31:0] ins_tab [12];
   logic [2:0]  typ_tab [12];
   logic [63:0] imm_tab [12];
   logic        ill_tab [12];

   exp_t        exp_q [$];
   exp_t        e_rec;
   exp_t        e_mon;
   int          n_vec = 0;
   int          n_err = 0;
   int          cur_idx = 0;
   logic [63:0] pc_ctr = 64'h1000;

   initial begin
      // type codes: u=0 j=1 i=2 b=3 s=4 r=5 n=6
      ins_tab[0]  = 32'hFFF00093; typ_tab[0]  = 3'd2; imm_tab[0]  = 64'hFFFF_FFFF_FFFF_FFFF; ill_tab[0]  = 1'b0;
      ins_tab[1]  = 32'h123452B7; typ_tab[1]  = 3'd0; imm_tab[1]  = 64'h0000_0000_1234_5000; ill_tab[1]  = 1'b0;
      ins_tab[2]  = 32'hFFDFF06F; typ_tab[2]  = 3'd1; imm_tab[2]  = 64'hFFFF_FFFF_FFFF_FFFC; ill_tab[2]  = 1'b0;
      ins_tab[3]  = 32'h0020A423; typ_tab[3]  = 3'd4; imm_tab[3]  = 64'h0000_0000_0000_0008; ill_tab[3]  = 1'b0;
      ins_tab[4]  = 32'hFE000CE3; typ_tab[4]  = 3'd3; imm_tab[4]  = 64'hFFFF_FFFF_FFFF_FFF8; ill_tab[4]  = 1'b0;
      ins_tab[5]  = 32'h0000007F; typ_tab[5]  = 3'd6; imm_tab[5]  = 64'h0;                   ill_tab[5]  = 1'b1;
      ins_tab[6]  = 32'h0FF0000F; typ_tab[6]  = 3'd6; imm_tab[6]  = 64'h0;                   ill_tab[6]  = 1'b0;
      ins_tab[7]  = 32'h002081B3; typ_tab[7]  = 3'd5; imm_tab[7]  = 64'h0;                   ill_tab[7]  = 1'b0;
      ins_tab[8]  = 32'hFF813083; typ_tab[8]  = 3'd2; imm_tab[8]  = 64'hFFFF_FFFF_FFFF_FFF8; ill_tab[8]  = 1'b0;
      ins_tab[9]  = 32'h80000097; typ_tab[9]  = 3'd0; imm_tab[9]  = 64'hFFFF_FFFF_8000_0000; ill_tab[9]  = 1'b0;
      ins_tab[10] = 32'h7FF080E7; typ_tab[10] = 3'd2; imm_tab[10] = 64'h0000_0000_0000_07FF; ill_tab[10] = 1'b0;
      ins_tab[11] = 32'h0000002F; typ_tab[11] = 3'd5; imm_tab[11] = 64'h0;                   ill_tab[11] = 1'b0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx);
      cur_idx      = idx;
      bus.in_valid = 1'b1;
      bus.in_ins   = ins_tab[idx];
      bus.in_pc    = pc_ctr;
      pc_ctr       = pc_ctr + 64'd4;
   endtask

   // stimulus side: record every accepted instruction
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) begin
            exp_q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            e_rec.pc  = bus.in_pc;
            e_rec.ins = ins_tab[cur_idx];
            e_rec.typ = typ_tab[cur_idx];
            e_rec.imm = imm_tab[cur_idx];
            e_rec.ill = ill_tab[cur_idx];
            exp_q.push_back(e_rec);
         end
      end
   end

   // monitor: every delivered output must be the oldest outstanding instruction
   always @(negedge clk) begin
      if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got ins %h pc %h, required no output", bus.out_ins, bus.out_pc);
         end else begin
            e_mon = exp_q.pop_front();
            chk("mon_pc",      bus.out_pc,                 e_mon.pc);
            chk("mon_ins",     {32'd0, bus.out_ins},       {32'd0, e_mon.ins});
            chk("mon_type",    {61'd0, bus.out_type},      {61'd0, e_mon.typ});
            chk("mon_imm",     bus.out_imm,                e_mon.imm);
            chk("mon_illegal", {63'd0, bus.out_illegal},   {63'd0, e_mon.ill});
            chk("mon_rd",      {59'd0, bus.out_rd},        {59'd0, e_mon.ins[11:7]});
            chk("mon_rs1",     {59'd0, bus.out_rs1},       {59'd0, e_mon.ins[19:15]});
            chk("mon_rs2",     {59'd0, bus.out_rs2},       {59'd0, e_mon.ins[24:20]});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   bit pend;

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pc     = 64'd0;
      bus.in_ins    = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) step();
      chk("rst_out_valid", {63'd0, bus.out_valid},   64'd0);
      chk("rst_in_ready",  {63'd0, bus.in_ready},    64'd1);
      chk("rst_illegal",   {63'd0, bus.out_illegal}, 64'd0);
      chk("rst_type",      {61'd0, bus.out_type},    64'd0);
      chk("rst_imm",       bus.out_imm,              64'd0);
      chk("rst_pc",        bus.out_pc,               64'd0);
      rst_n = 1'b1;
      step();

      // single ADDI, 1-cycle latency
      bus.out_ready = 1'b1;
      drive(0);
      step();
      bus.in_valid = 1'b0;
      chk("addi_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("addi_type",  {61'd0, bus.out_type},  64'd2);
      chk("addi_imm",   bus.out_imm,            64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_rd",    {59'd0, bus.out_rd},    64'd1);
      chk("addi_pc",    bus.out_pc,             64'h1000);
      step();

      // back-to-back stream, one output per cycle
      for (int k = 1; k <= 4; k++) begin
         drive(k);
         step();
         chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("stream_ins",   {32'd0, bus.out_ins},   {32'd0, ins_tab[k]});
         chk("stream_ready", {63'd0, bus.in_ready},  64'd1);
      end
      bus.in_valid = 1'b0;
      step();
      chk("stream_drained", {63'd0, bus.out_valid}, 64'd0);

      // backpressure: two accepted, third stalls until the skid drains
      bus.out_ready = 1'b0;
      drive(5);
      step();
      chk("bp_ready_one", {63'd0, bus.in_ready}, 64'd1);
      drive(6);
      step();
      chk("bp_ready_two", {63'd0, bus.in_ready},  64'd0);
      chk("bp_valid_two", {63'd0, bus.out_valid}, 64'd1);
      drive(7);
      step();
      chk("bp_ready_hold", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_ins_hold",   {32'd0, bus.out_ins},  {32'd0, ins_tab[5]});
      bus.out_ready = 1'b1;
      step();
      chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
      chk("bp_ins_second", {32'd0, bus.out_ins},  {32'd0, ins_tab[6]});
      step();
      bus.in_valid = 1'b0;
      chk("bp_ins_third",  {32'd0, bus.out_ins},  {32'd0, ins_tab[7]});
      step();
      chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);

      // flush while full with a new instruction offered
      bus.out_ready = 1'b0;
      drive(8);
      step();
      drive(9);
      step();
      chk("fl_full", {63'd0, bus.in_ready}, 64'd0);
      drive(10);
      flush = 1'b1;
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("fl_ready", {63'd0, bus.in_ready},  64'd1);
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("fl_nothing", {63'd0, bus.out_valid}, 64'd0);

      // illegal opcode, fence, negative U-type
      drive(5);
      step();
      chk("ill_type", {61'd0, bus.out_type},    64'd6);
      chk("ill_imm",  bus.out_imm,              64'd0);
      chk("ill_flag", {63'd0, bus.out_illegal}, 64'd1);
      drive(6);
      step();
      chk("fence_type", {61'd0, bus.out_type},    64'd6);
      chk("fence_flag", {63'd0, bus.out_illegal}, 64'd0);
      drive(9);
      step();
      chk("auipc_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);
      bus.in_valid = 1'b0;
      step();

      // random valid/ready/flush with a mid-stream async reset
      pend = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c == 300) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_valid",   {63'd0, bus.out_valid},   64'd0);
            chk("arst_ready",   {63'd0, bus.in_ready},    64'd1);
            chk("arst_illegal", {63'd0, bus.out_illegal}, 64'd0);
            chk("arst_type",    {61'd0, bus.out_type},    64'd0);
            chk("arst_imm",     bus.out_imm,              64'd0);
            exp_q.delete();
            bus.in_valid = 1'b0;
            flush        = 1'b0;
            pend         = 1'b0;
            step();
            rst_n = 1'b1;
            chk("arst_release", {63'd0, bus.out_valid}, 64'd0);
            continue;
         end
         if (!pend) begin
            if ($urandom_range(0, 2) != 0) begin
               drive($urandom_range(0, 11));
               pend = 1'b1;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 29) == 0);
         if (pend && (flush || bus.in_ready)) pend = 1'b0;
         step();
      end
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      chk("final_outstanding", exp_q.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
